// File: rtl/biu_constants_pkg.sv
// rtl/biu_constants_pkg.sv - bus interface unit shared constants (transfer size encoding)
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

endpackage

// File: rtl/riscv_arb_pkg.sv
// rtl/riscv_arb_pkg.sv - requester identifiers for the memory arbiter
package riscv_arb_pkg;

    // One bit identifies which CPU-side port issued an access.
    typedef logic port_id_t;

    localparam port_id_t PORT_IMEM = 1'b0;
    localparam port_id_t PORT_DMEM = 1'b1;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// rtl/riscv_mem_arbiter_if.sv - CPU-port and BIU-port signal bundle for the memory arbiter
//
// slave  : arbiter view (takes requests from both ports and acks from memory)
// master : environment view (drives port requests and memory acks)
interface riscv_mem_arbiter_if #(
    parameter int XLEN = 32
);
    // port 0 (instruction fetch)
    logic                         p0_req_i;
    logic [XLEN-1:0]              p0_adr_i;
    biu_constants_pkg::biu_size_t p0_size_i;
    logic                         p0_we_i;
    logic [XLEN-1:0]              p0_d_i;
    logic                         p0_gnt_o;
    logic                         p0_ack_o;
    logic [XLEN-1:0]              p0_q_o;
    // port 1 (data load/store)
    logic                         p1_req_i;
    logic [XLEN-1:0]              p1_adr_i;
    biu_constants_pkg::biu_size_t p1_size_i;
    logic                         p1_we_i;
    logic [XLEN-1:0]              p1_d_i;
    logic                         p1_gnt_o;
    logic                         p1_ack_o;
    logic [XLEN-1:0]              p1_q_o;
    // memory side
    logic                         req_o;
    logic [XLEN-1:0]              adr_o;
    biu_constants_pkg::biu_size_t size_o;
    logic                         we_o;
    logic [XLEN-1:0]              d_o;
    logic                         ack_i;
    logic [XLEN-1:0]              q_i;
    logic                         busy_o;

    modport slave (
        input  p0_req_i, p0_adr_i, p0_size_i, p0_we_i, p0_d_i,
        output p0_gnt_o, p0_ack_o, p0_q_o,
        input  p1_req_i, p1_adr_i, p1_size_i, p1_we_i, p1_d_i,
        output p1_gnt_o, p1_ack_o, p1_q_o,
        output req_o, adr_o, size_o, we_o, d_o, busy_o,
        input  ack_i, q_i
    );

    modport master (
        output p0_req_i, p0_adr_i, p0_size_i, p0_we_i, p0_d_i,
        input  p0_gnt_o, p0_ack_o, p0_q_o,
        output p1_req_i, p1_adr_i, p1_size_i, p1_we_i, p1_d_i,
        input  p1_gnt_o, p1_ack_o, p1_q_o,
        input  req_o, adr_o, size_o, we_o, d_o, busy_o,
        output ack_i, q_i
    );

endinterface

// File: rtl/riscv_arb_owner_fifo.sv
// rtl/riscv_arb_owner_fifo.sv - in-order FIFO of the port id owning each outstanding access
//
// clk_i/rst_ni : clock, synchronous active-low reset
// push_i       : enqueue push_id_i (ignored when full and not popping)
// pop_i        : dequeue head (ignored when empty)
// head_o       : owner of the oldest outstanding access
// empty_o      : nothing outstanding
// full_o       : DEPTH accesses outstanding
module riscv_arb_owner_fifo
    import riscv_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  port_id_t push_id_i,
    input  logic     pop_i,
    output port_id_t head_o,
    output logic     empty_o,
    output logic     full_o
);
    localparam int               PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CW      = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]    LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

    port_id_t        mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (cnt == '0);
    assign full_o  = (cnt == DEPTH_C);
    assign head_o  = mem[rd_ptr];

    // Pop is evaluated against the pre-push state, so an entry pushed this
    // cycle can never be retired by the same cycle's ack.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= PORT_IMEM;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id_i;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - round-robin arbiter sharing one BIU port between fetch and data
//
// clk_i  : clock
// rst_ni : synchronous active-low reset
// bus    : port 0 / port 1 request-grant-ack bundles, memory request/ack side, busy_o
module riscv_mem_arbiter
    import biu_constants_pkg::*;
    import riscv_arb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    riscv_mem_arbiter_if.slave  bus
);
    port_id_t        rr_last;
    port_id_t        winner;
    port_id_t        sel;
    port_id_t        head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            slot_free;
    logic            req;
    logic [XLEN-1:0] adr_mux;
    logic [XLEN-1:0] d_mux;

    // An ack retiring the head frees a slot in the same cycle.
    assign slot_free = ~fifo_full | bus.ack_i;

    always_comb begin
        winner = PORT_IMEM;
        if (bus.p0_req_i && bus.p1_req_i) winner = ~rr_last;
        else if (bus.p1_req_i)            winner = PORT_DMEM;
    end

    assign req          = (bus.p0_req_i | bus.p1_req_i) & slot_free;
    assign bus.req_o    = req;
    assign bus.p0_gnt_o = req & (winner == PORT_IMEM);
    assign bus.p1_gnt_o = req & (winner == PORT_DMEM);

    // Idle cycles present port 0's operands so the bus never floats.
    assign sel     = req ? winner : PORT_IMEM;
    assign adr_mux = (sel == PORT_DMEM) ? bus.p1_adr_i : bus.p0_adr_i;
    assign d_mux   = (sel == PORT_DMEM) ? bus.p1_d_i   : bus.p0_d_i;

    assign bus.adr_o  = adr_mux;
    assign bus.d_o    = d_mux;
    assign bus.size_o = (sel == PORT_DMEM) ? bus.p1_size_i : bus.p0_size_i;
    assign bus.we_o   = (sel == PORT_DMEM) ? bus.p1_we_i   : bus.p0_we_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_last <= PORT_DMEM;
        end else if (req) begin
            rr_last <= winner;
        end
    end

    riscv_arb_owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (req),
        .push_id_i (winner),
        .pop_i     (bus.ack_i),
        .head_o    (head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    assign bus.p0_ack_o = bus.ack_i & ~fifo_empty & (head == PORT_IMEM);
    assign bus.p1_ack_o = bus.ack_i & ~fifo_empty & (head == PORT_DMEM);
    assign bus.p0_q_o   = bus.q_i;
    assign bus.p1_q_o   = bus.q_i;
    assign bus.busy_o   = ~fifo_empty;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed vector bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;
    import biu_constants_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] D0 = 32'hCAFE0000;
    localparam logic [31:0] D1 = 32'h12345678;

    typedef struct {
        logic        rst_n;
        logic        r0;
        logic        r1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        we1;
        logic        ack;
        logic [31:0] q;
        logic        e_req;
        logic        e_g0;
        logic        e_g1;
        logic        e_k0;
        logic        e_k1;
        logic [31:0] e_adr;
        logic        e_we;
        logic [31:0] e_d;
        biu_size_t   e_sz;
        logic        e_busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t tbl[$];

    riscv_mem_arbiter_if #(.XLEN(32)) bus ();

    riscv_mem_arbiter #(
        .XLEN  (32),
        .DEPTH (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle, check combinational outputs mid-cycle.
    task automatic apply(input vec_t v, input string tag);
        rst_n         = v.rst_n;
        bus.p0_req_i  = v.r0;
        bus.p1_req_i  = v.r1;
        bus.p0_adr_i  = v.a0;
        bus.p1_adr_i  = v.a1;
        bus.p1_we_i   = v.we1;
        bus.ack_i     = v.ack;
        bus.q_i       = v.q;
        #2;
        chk({tag, " req_o"},    32'(bus.req_o),    32'(v.e_req));
        chk({tag, " p0_gnt"},   32'(bus.p0_gnt_o), 32'(v.e_g0));
        chk({tag, " p1_gnt"},   32'(bus.p1_gnt_o), 32'(v.e_g1));
        chk({tag, " p0_ack"},   32'(bus.p0_ack_o), 32'(v.e_k0));
        chk({tag, " p1_ack"},   32'(bus.p1_ack_o), 32'(v.e_k1));
        chk({tag, " adr_o"},    bus.adr_o,         v.e_adr);
        chk({tag, " we_o"},     32'(bus.we_o),     32'(v.e_we));
        chk({tag, " d_o"},      bus.d_o,           v.e_d);
        chk({tag, " size_o"},   32'(bus.size_o),   32'(v.e_sz));
        chk({tag, " busy_o"},   32'(bus.busy_o),   32'(v.e_busy));
        chk({tag, " p0_q"},     bus.p0_q_o,        v.q);
        chk({tag, " p1_q"},     bus.p1_q_o,        v.q);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.p0_req_i  = 1'b0;
        bus.p1_req_i  = 1'b0;
        bus.p0_adr_i  = '0;
        bus.p1_adr_i  = '0;
        bus.p0_size_i = WORD;
        bus.p1_size_i = HWORD;
        bus.p0_we_i   = 1'b0;
        bus.p1_we_i   = 1'b0;
        bus.p0_d_i    = D0;
        bus.p1_d_i    = D1;
        bus.ack_i     = 1'b0;
        bus.q_i       = '0;
        repeat (2) @(posedge clk);
        #1;

        // rst r0 r1 a0 a1 we1 ack q | req g0 g1 k0 k1 adr we d sz busy
        // reset state, stray ack while empty
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,         L,L,L,L,L,32'h0,L,D0,WORD,L});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,H,32'h55,        L,L,L,L,L,32'h0,L,D0,WORD,L});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,         L,L,L,L,L,32'h0,L,D0,WORD,L});
        // both requesting, ack one cycle after each issue
        tbl.push_back('{H,H,H,32'h1000,32'h2000,L,L,32'h0,        H,H,L,L,L,32'h1000,L,D0,WORD,L});
        tbl.push_back('{H,H,H,32'h1000,32'h2000,L,H,32'hDEADBEEF, H,L,H,H,L,32'h2000,L,D1,HWORD,H});
        tbl.push_back('{H,H,H,32'h1000,32'h2000,L,H,32'h11111111, H,H,L,L,H,32'h1000,L,D0,WORD,H});
        tbl.push_back('{H,H,H,32'h1000,32'h2000,L,H,32'hDEADBEEF, H,L,H,H,L,32'h2000,L,D1,HWORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,H,32'h22,             L,L,L,L,H,32'h0,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,              L,L,L,L,L,32'h0,L,D0,WORD,L});
        // interleaved A/B/C, acks spaced three cycles apart
        tbl.push_back('{H,H,L,32'h100,32'h0,L,L,32'h0,    H,H,L,L,L,32'h100,L,D0,WORD,L});
        tbl.push_back('{H,L,H,32'h0,32'h200,L,L,32'h0,    H,L,H,L,L,32'h200,L,D1,HWORD,H});
        tbl.push_back('{H,H,L,32'h300,32'h0,L,H,32'hA1,   H,H,L,H,L,32'h300,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,      L,L,L,L,L,32'h0,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,      L,L,L,L,L,32'h0,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,H,32'hB2,     L,L,L,L,H,32'h0,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,      L,L,L,L,L,32'h0,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,      L,L,L,L,L,32'h0,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,H,32'hC3,     H&L,L,L,H,L,32'h0,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,      L,L,L,L,L,32'h0,L,D0,WORD,L});
        // single requester p1 with writes
        tbl.push_back('{H,L,H,32'h0,32'h400,H,L,32'h0,    H,L,H,L,L,32'h400,H,D1,HWORD,L});
        tbl.push_back('{H,L,H,32'h0,32'h404,H,H,32'h0,    H,L,H,L,H,32'h404,H,D1,HWORD,H});
        tbl.push_back('{H,L,H,32'h0,32'h408,H,H,32'h0,    H,L,H,L,H,32'h408,H,D1,HWORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,H,32'h0,      L,L,L,L,H,32'h0,L,D0,WORD,H});
        tbl.push_back('{H,L,L,32'h0,32'h0,L,L,32'h0,      L,L,L,L,L,32'h0,L,D0,WORD,L});

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // fill to capacity, then ack and reissue in the same cycle
        apply('{L,L,L,32'h0,32'h0,L,L,32'h0,     L,L,L,L,L,32'h0,L,D0,WORD,L}, "full_rst");
        apply('{H,L,H,32'h0,32'h500,L,L,32'h0,   H,L,H,L,L,32'h500,L,D1,HWORD,L}, "full_g1");
        apply('{H,L,H,32'h0,32'h504,L,L,32'h0,   H,L,H,L,L,32'h504,L,D1,HWORD,H}, "full_g2");
        apply('{H,L,H,32'h0,32'h508,L,L,32'h0,   L,L,L,L,L,32'h0,L,D0,WORD,H}, "full_block");
        apply('{H,L,H,32'h0,32'h508,L,H,32'h77,  H,L,H,L,H,32'h508,L,D1,HWORD,H}, "full_ackgnt");
        apply('{H,L,H,32'h0,32'h50C,L,L,32'h0,   L,L,L,L,L,32'h0,L,D0,WORD,H}, "full_still");

        // reset with two accesses outstanding; later acks must be ignored
        apply('{L,L,L,32'h0,32'h0,L,L,32'h0,     L,L,L,L,L,32'h0,L,D0,WORD,H}, "mid_rst");
        apply('{H,L,L,32'h0,32'h0,L,H,32'h88,    L,L,L,L,L,32'h0,L,D0,WORD,L}, "mid_ack1");
        apply('{H,L,L,32'h0,32'h0,L,H,32'h99,    L,L,L,L,L,32'h0,L,D0,WORD,L}, "mid_ack2");
        apply('{H,H,H,32'h600,32'h700,L,L,32'h0, H,H,L,L,L,32'h600,L,D0,WORD,L}, "mid_rr0");
        apply('{H,H,H,32'h600,32'h700,L,L,32'h0, H,L,H,L,L,32'h700,L,D1,HWORD,H}, "mid_rr1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one memory-system request port (BIU side) between two CPU-side requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Round-robin arbitration on request cycles.
- Tracks up to DEPTH outstanding accesses, in issue order, so each in-order ack_i/q_i is routed back to the port that issued it.
- Sits between the per-port memory access buffers and the single bus interface unit.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 2, maximum outstanding (issued, unacknowledged) accesses; >=1.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- p0_req_i  input  1  port 0 access request.
- p0_adr_i  input  XLEN  port 0 address.
- p0_size_i  input  biu_size_t  port 0 transfer size.
- p0_we_i  input  1  port 0 write enable.
- p0_d_i  input  XLEN  port 0 write data.
- p0_gnt_o  output  1  port 0 request accepted this cycle.
- p0_ack_o  output  1  port 0 access completed.
- p0_q_o  output  XLEN  port 0 read data.
- p1_req_i … p1_q_o: identical set for port 1.
- req_o  output  1  memory request; accepted in the cycle it is asserted.
- adr_o  output  XLEN  memory address.
- size_o  output  biu_size_t  memory size.
- we_o  output  1  memory write enable.
- d_o  output  XLEN  memory write data.
- ack_i  input  1  memory completion, strictly in issue order.
- q_i  input  XLEN  memory read data, valid with ack_i.
- busy_o  output  1  outstanding count != 0.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous, active-low; it is sampled only on a rising clk_i edge.
- Reset state: outstanding count=0, owner FIFO empty, rr_last=1, so port 0 wins the first contention.
- Reset mid-operation: all in-flight accesses are forgotten; later ack_i pulses are ignored.
- Slot availability (combinational): slot_free = (cnt < DEPTH) | ack_i. A pop in the same cycle frees a slot.
- Arbitration (combinational, zero latency):
  - Only one port requesting: winner = that port.
  - Both requesting: winner = ~rr_last.
  - req_o = (p0_req_i | p1_req_i) & slot_free.
  - pN_gnt_o = req_o & (winner==N).
  - adr_o/size_o/we_o/d_o are muxed from the winner; they are driven from port 0 when req_o=0.
- rr_last update: rr_last <= winner on every cycle with req_o=1; otherwise it holds.
- A non-granted requester keeps pN_req_i and its operands stable until granted.
- Owner FIFO (DEPTH entries x 1 bit):
  - Push winner on req_o.
  - Pop head on ack_i when non-empty.
  - Push and pop in the same cycle are both performed; count unchanged.
  - Pointers wrap modulo DEPTH.
- Counter: cnt width $clog2(DEPTH+1); cnt += req_o, cnt -= (ack_i & nonempty).
- Ack routing:
  - pN_ack_o = ack_i & nonempty & (head==N).
  - p0_q_o = p1_q_o = q_i (unconditional broadcast).
  - Latency from ack_i to pN_ack_o is zero.
- ack_i while empty: ignored, no state change.
- Zero-latency memory: a request issued with ack_i in the same cycle (FIFO empty) is not acknowledged by that ack; ack applies only to an already-queued head.
- Full (cnt==DEPTH, ack_i=0): req_o=0 and both grants are 0; operands are held by the requesters.

Decomposition:
- biu_size_t comes from biu_constants_pkg (existing).
- Add localparam typedef port_id_t (1 bit) to a small riscv_arb_pkg, with constants PORT_IMEM=0, PORT_DMEM=1.
- One sub-module, riscv_arb_owner_fifo: DEPTH x 1-bit in-order FIFO with sync active-low reset, push/pop/head/empty/full.
- Arbitration, muxing and routing stay in the top.

Test Plan:
- Reset, no requests: all outputs 0, busy_o=0. Then ack_i=1 for one cycle → no pN_ack_o, cnt stays 0.
- Both req every cycle, DEPTH=2, ack_i one cycle after each issue:
  - grants alternate p0,p1,p0,p1.
  - acks route p0,p1,p0,p1.
  - p0_q_o carries the q_i value tied to each p0 ack (e.g. 0xDEADBEEF).
- Fill to capacity with ack_i=0: two p1 grants, then third request → req_o=0, p1_gnt_o=0. Next cycle ack_i=1 → p1_ack_o=1 and req_o=1 in the same cycle; cnt stays 2.
- Interleaved order: issue p0 A=0x100, p1 B=0x200, p0 C=0x300, with ack_i pulses spaced 3 cycles apart → pN_ack_o sequence p0,p1,p0; adr_o matched 0x100,0x200,0x300 at issue.
- Reset mid-operation: two outstanding accesses, rst_ni=0 for 1 cycle, then ack_i pulses → no pN_ack_o, busy_o=0, next contention grants p0 first.
- Single requester p1 with writes: we_o=1, d_o=p1_d_i=0x12345678, size_o=p1_size_i for every grant. Port 0 idle never receives an ack.
